// File: rtl/imem_responder.sv
// Instruction-memory responder: serves word fetches over a valid/ready
// request channel and returns instruction words through a read stage
// followed by a 2-entry response FIFO.
// Optional feature macro: IMEM_ERR_EN (misaligned / out-of-range fetches
// return an access fault with a NOP word instead of reading the array).
module imem_responder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_ro,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_ro,
  output logic              rsp_err_ro,
  input  logic              ld_we_i,
  input  logic [IDX_W-1:0]  ld_addr_i,
  input  logic [31:0]       ld_data_i
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             bad;
  logic             accept;
  logic             pop;
  logic             push;

  // cnt counts the read stage plus FIFO occupancy (0..2)
  logic [1:0]       cnt;
  logic [1:0]       cnt_n;
  logic [1:0]       fifo_cnt;
  logic [1:0]       fifo_cnt_n;

  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             rd_err;

  logic [31:0]      fifo_data [2];
  logic [1:0]       fifo_err;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             rd_ptr_n;
  logic [31:0]      head_data_n;
  logic             head_err_n;

  assign idx         = req_addr_i[IDX_W+1:2];
  assign pop         = rsp_valid_ro & rsp_ready_i;
  assign req_ready_o = (cnt < 2'd2) | pop;
  assign accept      = req_valid_i & req_ready_o;
  assign push        = rd_valid;
  assign fifo_cnt    = cnt - {1'b0, rd_valid};

`ifdef IMEM_ERR_EN
  assign bad = (req_addr_i[1:0] != 2'b00) | (|req_addr_i[ADDR_W-1:IDX_W+2]);
`else
  logic unused_addr;
  assign bad         = 1'b0;
  assign unused_addr = ^{req_addr_i[ADDR_W-1:IDX_W+2], req_addr_i[1:0]};
`endif

  // Loader write and read-stage capture; same-index collisions read old data
  always_ff @(posedge clk) begin
    if (ld_we_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
    if (accept) begin
      rd_data <= bad ? NOP : mem[idx];
      rd_err  <= bad;
    end
  end

  // FIFO storage, written from the read stage one edge after accept
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_err[wr_ptr]  <= rd_err;
    end
  end

  // Next outstanding count and next FIFO head, so outputs can be registered
  always_comb begin
    cnt_n = cnt;
    if (accept && !pop) begin
      cnt_n = cnt + 2'd1;
    end else if (!accept && pop) begin
      cnt_n = cnt - 2'd1;
    end
    fifo_cnt_n = fifo_cnt + {1'b0, push} - {1'b0, pop};
    rd_ptr_n   = rd_ptr ^ pop;
    // The entry being pushed this edge may become the head immediately
    if (push && (wr_ptr == rd_ptr_n)) begin
      head_data_n = rd_data;
      head_err_n  = rd_err;
    end else begin
      head_data_n = fifo_data[rd_ptr_n];
      head_err_n  = fifo_err[rd_ptr_n];
    end
  end

  // Control state and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rd_valid     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      rsp_valid_ro <= 1'b0;
      rsp_data_ro  <= '0;
      rsp_err_ro   <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      rd_valid     <= accept;
      rd_ptr       <= rd_ptr_n;
      rsp_valid_ro <= (fifo_cnt_n != 2'd0);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (fifo_cnt_n != 2'd0) begin
        rsp_data_ro <= head_data_n;
        rsp_err_ro  <= head_err_n;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed sequences, a vector
// table, and randomized traffic against a queue-based reference model.
module tb_imem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  imem_responder #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_ro(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_ro(rsp_data), .rsp_err_ro(rsp_err),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          avail;
  } rsp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          we;
    int          widx;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic [31:0] mm [DEPTH];
  rsp_t        q[$];
  logic [31:0] popq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          dut_acc;
  bit          dut_pop;
  logic [31:0] pop_data;
  logic        pop_err;
  int          pop_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a response exists per accepted request, visible two cycles
  // after its accept cycle, returned in order.
  function automatic void model_rsp(input logic [31:0] a, output logic [31:0] d, output logic e);
    longint unsigned ua = a;
    d = mm[int'((ua / 4) % DEPTH)];
    e = 1'b0;
`ifdef IMEM_ERR_EN
    if ((ua % 4) != 0 || ua >= DEPTH * 4) begin
      d = 32'h0000_0013;
      e = 1'b1;
    end
`endif
  endfunction

  task automatic tick();
    rsp_t r;
    logic ev, epop, erdy;
    #4;
    ev   = (q.size() > 0) && (q[0].avail <= cyc);
    epop = ev && rsp_ready;
    erdy = (q.size() < 2) || epop;
    chk("req_ready", req_ready, erdy);
    chk("rsp_valid", rsp_valid, ev);
    if (ev && rsp_valid) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_err", rsp_err, q[0].err);
    end
    dut_acc = req_valid && req_ready;
    dut_pop = rsp_valid && rsp_ready;
    if (dut_pop) begin
      pop_data = rsp_data;
      pop_err  = rsp_err;
      pop_cyc  = cyc;
    end
    if (epop) r = q.pop_front();
    if (req_valid && erdy) begin
      model_rsp(req_addr, r.data, r.err);
      r.avail = cyc + 2;
      q.push_back(r);
    end
    if (ld_we) mm[ld_addr] = ld_data;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    ld_we     = 1'b0;
    popq.delete();
    for (int n = 0; n < 12; n++) begin
      tick();
      if (dut_pop) popq.push_back(pop_data);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a, input bit we, input int wi, input logic [31:0] wd,
                           output logic [31:0] d, output logic e, output bit ok);
    ok = 1'b0;
    d  = '0;
    e  = 1'b0;
    rsp_ready = 1'b1;
    req_addr  = a;
    req_valid = 1'b1;
    ld_we     = we;
    ld_addr   = 10'(wi);
    ld_data   = wd;
    for (int n = 0; n < 10; n++) begin
      tick();
      ld_we = 1'b0;
      if (dut_acc) break;
    end
    req_valid = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      tick();
      if (dut_pop) begin
        d  = pop_data;
        e  = pop_err;
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t        vt[7];
    int          n_acc;
    int          first_acc;
    int          pc[$];
    logic [31:0] pd[$];
    logic [31:0] d;
    logic        e;
    bit          ok;

    vt[0] = '{"rdfirst_old", 32'd20, 1'b1, 5, 32'hDEADBEEF, 32'h11111111, 1'b0};
    vt[1] = '{"rdfirst_new", 32'd20, 1'b0, 0, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[4] = '{"word0",       32'h0,  1'b0, 0, 32'h0, 32'hA0, 1'b0};
    vt[5] = '{"word3",       32'hC,  1'b0, 0, 32'h0, 32'hA3, 1'b0};
`ifdef IMEM_ERR_EN
    vt[2] = '{"wrap_1000",   32'h1000, 1'b0, 0, 32'h0, 32'h13, 1'b1};
    vt[3] = '{"unaligned_2", 32'h2,    1'b0, 0, 32'h0, 32'h13, 1'b1};
    vt[6] = '{"wrap_1007",   32'h1007, 1'b0, 0, 32'h0, 32'h13, 1'b1};
`else
    vt[2] = '{"wrap_1000",   32'h1000, 1'b0, 0, 32'h0, 32'hA0, 1'b0};
    vt[3] = '{"unaligned_2", 32'h2,    1'b0, 0, 32'h0, 32'hA0, 1'b0};
    vt[6] = '{"wrap_1007",   32'h1007, 1'b0, 0, 32'h0, 32'hA1, 1'b0};
`endif

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_ready", req_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Preload the whole array so the model is fully known
    for (int i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = 10'(i);
      ld_data = (i < 4) ? 32'hA0 + 32'(i) : (i == 5) ? 32'h11111111 : $urandom;
      tick();
    end
    ld_we = 1'b0;

    // Back-to-back fetches at full throughput
    rsp_ready = 1'b1;
    n_acc = 0;
    first_acc = -1;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i < 4);
      req_addr  = 32'(4 * i);
      if (i < 4 && first_acc < 0) first_acc = cyc;
      tick();
      if (dut_acc) n_acc++;
      if (dut_pop) begin
        pd.push_back(pop_data);
        pc.push_back(pop_cyc);
      end
    end
    chk("t1_accepts", n_acc, 4);
    chk("t1_npops", pd.size(), 4);
    if (pd.size() == 4) begin
      chk("t1_latency", pc[0], first_acc + 2);
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", pd[i], 32'hA0 + 32'(i));
        chk("t1_consecutive", pc[i], pc[0] + i);
      end
    end

    // Response stall: only two requests are absorbed
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'(24 + 4 * n_acc);
      tick();
      if (dut_acc) n_acc++;
    end
    chk("stall_accepts", n_acc, 2);
    chk("stall_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    req_addr  = 32'(24 + 4 * n_acc);
    tick();
    chk("pop_with_accept", {30'b0, dut_acc, dut_pop}, 32'd3);
    chk("stall_head", pop_data, mm[6]);
    drain();
    chk("stall_rest_n", popq.size(), 2);
    if (popq.size() == 2) begin
      chk("stall_rest0", popq[0], mm[7]);
      chk("stall_rest1", popq[1], mm[8]);
    end

    // Reset while two responses are outstanding
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    for (int i = 0; i < 4; i++) tick();
    req_valid = 1'b0;
    chk("prerst_valid", rsp_valid, 1);
    chk("prerst_ready", req_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_data", rsp_data, 0);
    chk("midrst_err", rsp_err, 0);
    chk("midrst_ready", req_ready, 1);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Vector table: read-first collision, address wrap and fault rules
    for (int i = 0; i < 7; i++) begin
      fetch_one(vt[i].addr, vt[i].we, vt[i].widx, vt[i].wdata, d, e, ok);
      chk({vt[i].name, "_done"}, ok, 1);
      chk({vt[i].name, "_data"}, d, vt[i].exp_data);
      chk({vt[i].name, "_err"}, e, vt[i].exp_err);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom % 4) != 0;
      req_addr  = (($urandom % 8) == 0) ? $urandom : {20'b0, 10'($urandom), 2'b00};
      rsp_ready = ($urandom % 3) != 0;
      ld_we     = ($urandom % 6) == 0;
      ld_addr   = 10'($urandom);
      ld_data   = $urandom;
      tick();
    end
    drain();
    chk("final_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
